// File: rtl/ft_stall_gen.sv
// ---------------------------------------------------------------------------
// ft_stall_gen
//
// Stall generator feeding the FreezeTime timer. It emulates memory latency by
// freezing the instruction and data buses for a number of cycles after each
// access, and periodically inserts a sync freeze (ext_stall) of SYNC_COST
// cycles after every TINTERVAL cycles of normal running.
//
// Request / stall handshake (applies to both buses):
//   A bus request (busX_read / busX_write) is a level held by the CPU until
//   the access completes. The access completes in the first cycle in which
//   the request is high and busX_stall is low. A request is sampled only in a
//   RUN cycle that is not an ack cycle; if its combined latency is >= 2 the
//   buses freeze for latency-1 cycles, followed by one ack cycle in which the
//   still-held request completes and is deliberately not sampled again.
//
// Ports:
//   clock        in   fabric clock
//   reset        in   synchronous, active-high reset
//   sim_Start    in   simulation started (level)
//   sim_End      in   simulation ended (level)
//   busI_read    in   instruction bus read request
//   busI_write   in   instruction bus write request
//   busD_read    in   data bus read request
//   busD_write   in   data bus write request
//   busI_stall   out  stall instruction bus
//   busD_stall   out  stall data bus
//   ext_stall    out  sync freeze active
//   sync_count   out  number of sync freezes entered (wraps at 2^32)
//   stall_total  out  cycles with any stall output high (wraps at 2^64)
//   o_dbg_state  out  current FSM state (IDLE=0, RUN=1, MEM_STALL=2,
//                     SYNC_STALL=3)
// ---------------------------------------------------------------------------
module ft_stall_gen #(
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_LATENCY = 1,
    parameter int TINTERVAL     = 1000,
    parameter int SYNC_COST     = 3,
    parameter int CNT_W         = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sim_Start,
    input  logic        sim_End,
    input  logic        busI_read,
    input  logic        busI_write,
    input  logic        busD_read,
    input  logic        busD_write,
    output logic        busI_stall,
    output logic        busD_stall,
    output logic        ext_stall,
    output logic [31:0] sync_count,
    output logic [63:0] stall_total,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RUN        = 2'd1,
        ST_MEM_STALL  = 2'd2,
        ST_SYNC_STALL = 2'd3
    } state_t;

    // One extra bit so that read+write latency on one bus cannot overflow.
    localparam int LW = CNT_W + 1;

    localparam logic [LW-1:0]    RD_LAT    = LW'(READ_LATENCY);
    localparam logic [LW-1:0]    WR_LAT    = WR_LAT_CALC();
    localparam logic [LW-1:0]    SYNC_LOAD = LW'(SYNC_COST);
    localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'((TINTERVAL > 0) ? (TINTERVAL - 1) : 0);
    localparam bit               SYNC_EN   = (TINTERVAL != 0);

    function automatic logic [LW-1:0] WR_LAT_CALC();
        return LW'(WRITE_LATENCY);
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t            r_state;
    logic [LW-1:0]     r_cnt;            // shared down-counter for both freezes
    logic [CNT_W-1:0]  r_int_cnt;        // RUN cycles since the last expiry
    logic              r_ack;            // current RUN cycle is an ack cycle
    logic              r_sync_pending;   // expiry seen while a mem stall started
    logic              r_busi_stall;
    logic              r_busd_stall;
    logic              r_ext_stall;
    logic [31:0]       r_sync_count;
    logic [63:0]       r_stall_total;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic              w_is_sim;
    logic [LW-1:0]     w_lat_i;
    logic [LW-1:0]     w_lat_d;
    logic [LW-1:0]     w_lat_max;
    logic [LW-1:0]     w_mem_load;
    logic              w_mem_go;
    logic              w_int_hit;
    logic              w_any_stall;

    assign w_is_sim   = sim_Start & ~sim_End;

    assign w_lat_i    = (busI_read  ? RD_LAT : '0) + (busI_write ? WR_LAT : '0);
    assign w_lat_d    = (busD_read  ? RD_LAT : '0) + (busD_write ? WR_LAT : '0);
    assign w_lat_max  = (w_lat_i >= w_lat_d) ? w_lat_i : w_lat_d;
    assign w_mem_load = w_lat_max - LW'(1);

    // A latency of 0 or 1 completes in the request cycle, so only >=2 stalls.
    // Requests in the ack cycle belong to the access that just completed.
    assign w_mem_go   = ~r_ack & (w_lat_max >= LW'(2));

    assign w_int_hit  = SYNC_EN & (r_int_cnt == INT_LAST);

    assign w_any_stall = r_busi_stall | r_busd_stall | r_ext_stall;

    // -----------------------------------------------------------------------
    // FSM with registered stall outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_int_cnt      <= '0;
            r_ack          <= 1'b0;
            r_sync_pending <= 1'b0;
            r_busi_stall   <= 1'b0;
            r_busd_stall   <= 1'b0;
            r_ext_stall    <= 1'b0;
            r_sync_count   <= '0;
            r_stall_total  <= '0;
        end else begin
            // Counts the cycles in which the registered outputs are high.
            if (w_any_stall) begin
                r_stall_total <= r_stall_total + 64'd1;
            end

            if (!w_is_sim) begin
                // Leaving simulation abandons any freeze in progress; the
                // interval counter, pending flag and statistics are kept.
                r_state      <= ST_IDLE;
                r_ack        <= 1'b0;
                r_busi_stall <= 1'b0;
                r_busd_stall <= 1'b0;
                r_ext_stall  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_RUN;
                        r_ack   <= 1'b0;
                    end

                    ST_RUN: begin
                        r_ack <= 1'b0;
                        if (r_sync_pending) begin
                            // Deferred sync: taken right after the ack cycle
                            // of the mem stall that delayed it.
                            r_sync_pending <= 1'b0;
                            r_state        <= ST_SYNC_STALL;
                            r_cnt          <= SYNC_LOAD;
                            r_busi_stall   <= 1'b1;
                            r_busd_stall   <= 1'b1;
                            r_ext_stall    <= 1'b1;
                            r_sync_count   <= r_sync_count + 32'd1;
                        end else begin
                            if (w_mem_go) begin
                                // Both buses freeze for the longer latency;
                                // a bus is only frozen if its own access
                                // would have stalled.
                                r_state      <= ST_MEM_STALL;
                                r_cnt        <= w_mem_load;
                                r_busi_stall <= (w_lat_i >= LW'(2));
                                r_busd_stall <= (w_lat_d >= LW'(2));
                            end

                            if (SYNC_EN) begin
                                if (w_int_hit) begin
                                    r_int_cnt <= '0;
                                    if (w_mem_go) begin
                                        // Mem stall wins; sync follows it.
                                        r_sync_pending <= 1'b1;
                                    end else begin
                                        r_state      <= ST_SYNC_STALL;
                                        r_cnt        <= SYNC_LOAD;
                                        r_busi_stall <= 1'b1;
                                        r_busd_stall <= 1'b1;
                                        r_ext_stall  <= 1'b1;
                                        r_sync_count <= r_sync_count + 32'd1;
                                    end
                                end else begin
                                    r_int_cnt <= r_int_cnt + CNT_W'(1);
                                end
                            end
                        end
                    end

                    ST_MEM_STALL: begin
                        if (r_cnt == LW'(1)) begin
                            r_state      <= ST_RUN;
                            r_ack        <= 1'b1;
                            r_busi_stall <= 1'b0;
                            r_busd_stall <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - LW'(1);
                        end
                    end

                    ST_SYNC_STALL: begin
                        // Return without an ack: held requests are fresh
                        // accesses from the CPU's point of view.
                        if (r_cnt == LW'(1)) begin
                            r_state      <= ST_RUN;
                            r_ack        <= 1'b0;
                            r_busi_stall <= 1'b0;
                            r_busd_stall <= 1'b0;
                            r_ext_stall  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - LW'(1);
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busI_stall  = r_busi_stall;
    assign busD_stall  = r_busd_stall;
    assign ext_stall   = r_ext_stall;
    assign sync_count  = r_sync_count;
    assign stall_total = r_stall_total;
    assign o_dbg_state = r_state;

endmodule
